// File: rtl/arbitro_memoria_tabuleiro.sv
// ---------------------------------------------------------------------------
// arbitro_memoria_tabuleiro
//
// Round-robin arbiter that shares the two 32x64 board memories (player 1 and
// player 2) among four requesters: 0 validator, 1 collider, 2 score, 3 VGA.
// A requester holds req for a burst of single-cycle accesses; MAX_BURST caps
// a burst whenever somebody else is waiting, so nobody starves.
//
// Ports
//   clk                       system clock, rising edge
//   resetGeral                synchronous, active-high reset
//   req[3:0]                  access request per requester
//   jogador[3:0]              board select per requester (0 = P1, 1 = P2)
//   wren[3:0]                 write enable per requester (0 = read)
//   addr_in[19:0]             row address, requester i uses [5i+4:5i]
//   wdata_in[255:0]           write data, requester i uses [64i+63:64i]
//   data_memoria_jogadorUm    P1 memory read port (1-cycle latency)
//   data_memoria_jogadorDois  P2 memory read port (1-cycle latency)
//   gnt[3:0]                  registered one-hot owner (or zero)
//   addr, data                shared memory address / write data
//   wrenP1, wrenP2            per-memory write enables
//   rdata, rvalid[3:0]        read return, one cycle after the read access
//   ocupado                   high whenever gnt is nonzero
// ---------------------------------------------------------------------------
module arbitro_memoria_tabuleiro #(
    parameter int unsigned MAX_BURST = 32
) (
    input  logic         clk,
    input  logic         resetGeral,
    input  logic [3:0]   req,
    input  logic [3:0]   jogador,
    input  logic [3:0]   wren,
    input  logic [19:0]  addr_in,
    input  logic [255:0] wdata_in,
    input  logic [63:0]  data_memoria_jogadorUm,
    input  logic [63:0]  data_memoria_jogadorDois,
    output logic [3:0]   gnt,
    output logic [4:0]   addr,
    output logic [63:0]  data,
    output logic         wrenP1,
    output logic         wrenP2,
    output logic [63:0]  rdata,
    output logic [3:0]   rvalid,
    output logic         ocupado
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;

    // Last driven address/data, replayed on cycles without an access.
    logic [4:0]  addr_q, addr_d;
    logic [63:0] data_q, data_d;

    // Pending read return: who issued it and which memory it targets.
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic        rd_sel_q, rd_sel_d;
    logic [63:0] rdata_q, rdata_d;

    logic        access;
    logic [7:0]  cnt_inc;
    logic        release_g;
    logic        found;
    logic [1:0]  found_idx;

    // Round-robin search: first set bit of r at or after start, wrapping 3->0.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic       hit;
        logic [1:0] idx;
        logic [1:0] cand;
        hit = 1'b0;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!hit && r[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
        return {hit, idx};
    endfunction

    assign access  = (state_q == ST_GRANT) && req[owner_q];
    assign cnt_inc = cnt_q + 8'd1;

    // -----------------------------------------------------------------------
    // State register (also holds the datapath flops)
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: every flop is reset, including the datapath holds, so the
        // outputs are defined zeros the cycle after reset and a read return
        // in flight is dropped.
        if (resetGeral) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            addr_q    <= 5'd0;
            data_q    <= 64'd0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= 2'd0;
            rd_sel_q  <= 1'b0;
            rdata_q   <= 64'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            rd_sel_q  <= rd_sel_d;
            rdata_q   <= rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        release_g = 1'b0;
        found     = 1'b0;
        found_idx = 2'd0;

        unique case (state_q)
            ST_IDLE: begin
                {found, found_idx} = rr_pick(req, ptr_q);
                if (found) begin
                    state_d = ST_GRANT;
                    owner_d = found_idx;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                // A req drop wins over a simultaneous burst-limit hit; both
                // release, and the outcome below is the same either way.
                release_g = !req[owner_q] || (cnt_inc == 8'(MAX_BURST));
                if (!release_g) begin
                    cnt_d = cnt_inc;
                end else begin
                    ptr_d = owner_q + 2'd1;
                    {found, found_idx} = rr_pick(req & ~(4'b0001 << owner_q), owner_q + 2'd1);
                    cnt_d = 8'd0;
                    if (found) begin
                        owner_d = found_idx;          // direct handover, no bubble
                    end else if (!req[owner_q]) begin
                        state_d = ST_IDLE;
                    end                               // else: nobody waiting, keep owner
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (combinational from the registered grant)
    // -----------------------------------------------------------------------
    always_comb begin
        gnt    = (state_q == ST_GRANT) ? (4'b0001 << owner_q) : 4'b0000;
        addr   = addr_q;
        data   = data_q;
        wrenP1 = 1'b0;
        wrenP2 = 1'b0;

        if (access) begin
            addr   = addr_in[int'(owner_q)*5 +: 5];
            data   = wdata_in[int'(owner_q)*64 +: 64];
            wrenP1 = wren[owner_q] & ~jogador[owner_q];
            wrenP2 = wren[owner_q] &  jogador[owner_q];
        end

        addr_d    = addr;
        data_d    = data;

        rd_pend_d = access & ~wren[owner_q];
        rd_idx_d  = owner_q;
        rd_sel_d  = jogador[owner_q];

        // The memory port carries the data addressed in the previous cycle,
        // so the return is a mux, not another register stage.
        rvalid  = rd_pend_q ? (4'b0001 << rd_idx_q) : 4'b0000;
        rdata   = rd_pend_q ? (rd_sel_q ? data_memoria_jogadorDois : data_memoria_jogadorUm)
                            : rdata_q;
        rdata_d = rdata;
        ocupado = |gnt;
    end

endmodule

// File: tb/tb_arbitro_memoria_tabuleiro.sv
// ---------------------------------------------------------------------------
// Testbench for arbitro_memoria_tabuleiro (MAX_BURST = 4).
// Two behavioural 32x64 memories with a registered read port model the
// board RAMs. Inputs change 1 time unit after the rising edge, outputs are
// checked 1 unit later.
// ---------------------------------------------------------------------------
module tb_arbitro_memoria_tabuleiro;

    logic         clk;
    logic         resetGeral;
    logic [3:0]   req, jogador, wren;
    logic [19:0]  addr_in;
    logic [255:0] wdata_in;
    logic [63:0]  p1_q, p2_q;
    logic [3:0]   gnt, rvalid;
    logic [4:0]   addr;
    logic [63:0]  data, rdata;
    logic         wrenP1, wrenP2, ocupado;

    logic [63:0]  mem1 [32];
    logic [63:0]  mem2 [32];

    int n_vec = 0;
    int n_err = 0;

    arbitro_memoria_tabuleiro #(.MAX_BURST(4)) u_dut (
        .clk                      (clk),
        .resetGeral               (resetGeral),
        .req                      (req),
        .jogador                  (jogador),
        .wren                     (wren),
        .addr_in                  (addr_in),
        .wdata_in                 (wdata_in),
        .data_memoria_jogadorUm   (p1_q),
        .data_memoria_jogadorDois (p2_q),
        .gnt                      (gnt),
        .addr                     (addr),
        .data                     (data),
        .wrenP1                   (wrenP1),
        .wrenP2                   (wrenP2),
        .rdata                    (rdata),
        .rvalid                   (rvalid),
        .ocupado                  (ocupado)
    );

    always #5 clk = ~clk;

    // Board memories: read-before-write, 1-cycle read latency.
    always @(posedge clk) begin
        p1_q <= mem1[addr];
        p2_q <= mem2[addr];
        if (wrenP1) mem1[addr] <= data;
        if (wrenP2) mem2[addr] <= data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_fields(input int i, input logic j, input logic w,
                              input logic [4:0] a, input logic [63:0] d);
        jogador[i]          = j;
        wren[i]             = w;
        addr_in[i*5 +: 5]   = a;
        wdata_in[i*64 +: 64] = d;
    endtask

    task automatic do_reset();
        resetGeral = 1'b1;
        req        = 4'b0000;
        next_cycle();
        resetGeral = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         acc [4];
        int         order [8];
        int         n_order, total, idle, idx;
        logic       started;
        logic [3:0] last_gnt, exp_gnt, prev_gnt;

        for (int i = 0; i < 32; i++) begin
            mem1[i] = 64'd0;
            mem2[i] = 64'd0;
        end
        mem2[7] = 64'hA5;
        mem1[5] = 64'hDEAD_BEEF;

        clk        = 1'b0;
        resetGeral = 1'b1;
        req        = 4'b0000;
        jogador    = 4'b0000;
        wren       = 4'b0000;
        addr_in    = 20'd0;
        wdata_in   = 256'd0;

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        resetGeral = 1'b0;
        settle();
        check("rst_gnt",     gnt,              0);
        check("rst_rvalid",  rvalid,           0);
        check("rst_rdata",   rdata,            0);
        check("rst_addr",    addr,             0);
        check("rst_data",    data,             0);
        check("rst_wren",    {wrenP1, wrenP2}, 0);
        check("rst_ocupado", ocupado,          0);

        // ---------------- single read: VGA, P2[7] ----------------
        set_fields(3, 1'b1, 1'b0, 5'd7, 64'd0);
        req = 4'b1000;
        settle();
        check("rd_gnt_pre", gnt, 4'b0000);
        next_cycle(); settle();
        check("rd_gnt",     gnt,              4'b1000);
        check("rd_addr",    addr,             7);
        check("rd_wren",    {wrenP1, wrenP2}, 0);
        check("rd_ocupado", ocupado,          1);
        next_cycle();
        req = 4'b0000;
        settle();
        check("rd_rvalid",    rvalid,           4'b1000);
        check("rd_rdata",     rdata,            64'hA5);
        check("rd_wren2",     {wrenP1, wrenP2}, 0);
        check("rd_addr_hold", addr,             7);
        next_cycle(); settle();
        check("rd_gnt_rel",    gnt,    4'b0000);
        check("rd_rvalid_off", rvalid, 4'b0000);
        check("rd_rdata_hold", rdata,  64'hA5);

        // ---------------- write routing: validator, P1[3] = 1 ----------------
        set_fields(0, 1'b0, 1'b1, 5'd3, 64'h1);
        req = 4'b0001;
        settle();
        next_cycle(); settle();
        check("wr_gnt",    gnt,    4'b0001);
        check("wr_wrenP1", wrenP1, 1);
        check("wr_wrenP2", wrenP2, 0);
        check("wr_addr",   addr,   3);
        check("wr_data",   data,   64'h1);
        next_cycle();
        req  = 4'b0000;
        wren = 4'b0000;
        settle();
        check("wr_wrenP1_once", wrenP1, 0);
        check("wr_no_rvalid",   rvalid, 4'b0000);
        next_cycle(); settle();
        check("wr_no_rvalid2", rvalid,  4'b0000);
        check("wr_mem",        mem1[3], 64'h1);

        // ---------------- round robin: all four, 2 accesses each ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_fields(i, 1'b0, 1'b0, 5'(10 + i), 64'd0);
            acc[i] = 0;
        end
        for (int i = 0; i < 8; i++) order[i] = -1;
        n_order  = 0;
        total    = 0;
        idle     = 0;
        started  = 1'b0;
        last_gnt = 4'b0000;
        req      = 4'b1111;
        settle();
        for (int cyc = 0; cyc < 30 && total < 8; cyc++) begin
            next_cycle();
            for (int i = 0; i < 4; i++) if (acc[i] >= 2) req[i] = 1'b0;
            settle();
            if (gnt != 4'b0000) begin
                started = 1'b1;
                idx = 0;
                for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
                if (gnt != last_gnt && n_order < 8) begin
                    order[n_order] = idx;
                    n_order++;
                end
                last_gnt = gnt;
                if ((gnt & req) != 4'b0000) begin
                    acc[idx]++;
                    total++;
                end
            end else if (started) begin
                idle++;
            end
        end
        check("rr_total",   total,   8);
        check("rr_idle",    idle,    0);
        check("rr_ngrants", n_order, 4);
        for (int k = 0; k < 4; k++) check($sformatf("rr_order%0d", k), order[k], k);
        req = 4'b0000;

        // ---------------- burst limit: VGA vs collider, MAX_BURST = 4 ----------------
        do_reset();
        set_fields(3, 1'b0, 1'b0, 5'd4, 64'd0);
        set_fields(1, 1'b1, 1'b0, 5'd9, 64'd0);
        req = 4'b1000;
        settle();
        prev_gnt = 4'b0000;
        for (int k = 1; k <= 26; k++) begin
            next_cycle();
            if (k == 1)  req = 4'b1010;
            if (k == 17) req = 4'b1000;   // collider withdraws while not granted
            settle();
            if (k <= 16) exp_gnt = (((k - 1) / 4) % 2 == 0) ? 4'b1000 : 4'b0010;
            else         exp_gnt = 4'b1000;
            check($sformatf("bl_gnt%0d", k),    gnt,    exp_gnt);
            check($sformatf("bl_rvalid%0d", k), rvalid, prev_gnt);
            prev_gnt = exp_gnt;
        end
        check("bl_wren", {wrenP1, wrenP2}, 0);

        // ---------------- reset mid-burst ----------------
        req = 4'b0000;
        do_reset();
        set_fields(1, 1'b0, 1'b0, 5'd5, 64'd0);
        set_fields(3, 1'b0, 1'b0, 5'd6, 64'd0);
        req = 4'b0010;
        settle();
        next_cycle(); settle();
        check("mr_gnt", gnt, 4'b0010);
        next_cycle(); settle();
        check("mr_rvalid", rvalid, 4'b0010);
        check("mr_rdata",  rdata,  64'hDEAD_BEEF);
        next_cycle();
        resetGeral = 1'b1;             // a read is issued in this cycle too
        settle();
        next_cycle();
        resetGeral = 1'b0;
        req        = 4'b1010;
        settle();
        check("mr_gnt0",     gnt,              0);
        check("mr_rvalid0",  rvalid,           0);
        check("mr_rdata0",   rdata,            0);
        check("mr_addr0",    addr,             0);
        check("mr_data0",    data,             0);
        check("mr_wren0",    {wrenP1, wrenP2}, 0);
        check("mr_ocupado0", ocupado,          0);
        next_cycle(); settle();
        check("mr_gnt_ptr0", gnt,    4'b0010);
        check("mr_rvalid1",  rvalid, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
